// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states, CSR
// addresses, interrupt cause codes, mstatus bit positions and update helpers.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WR_EPC      = 3'd1,
    WR_CAUSE    = 3'd2,
    WR_TVAL     = 3'd3,
    WR_STATUS   = 3'd4,
    MRET_STATUS = 3'd5,
    REDIRECT    = 3'd6
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [4:0] CODE_MSI = 5'd3;
  localparam logic [4:0] CODE_MTI = 5'd7;
  localparam logic [4:0] CODE_MEI = 5'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] MTVEC_MODE_VEC = 2'b01;

  function automatic logic [63:0] trap_mstatus(input logic [63:0] s);
    logic [63:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [63:0] mret_mstatus(input logic [63:0] s);
    logic [63:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_irq_prio.sv
// Fixed-priority machine interrupt encoder: MEI > MSI > MTI, gated by the
// global interrupt enable.
module trap_irq_prio
  import trap_pkg::*;
(
  input  logic [63:0] mip_i,
  input  logic [63:0] mie_i,
  input  logic        gie_i,
  output logic        pending_o,
  output logic [4:0]  code_o
);

  logic [63:0] en;

  assign en        = mip_i & mie_i;
  assign pending_o = gie_i & (|en);

  always_comb begin
    code_o = 5'd0;
    if (en[CODE_MEI])      code_o = CODE_MEI;
    else if (en[CODE_MSI]) code_o = CODE_MSI;
    else if (en[CODE_MTI]) code_o = CODE_MTI;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: writes mepc/mcause/mtval/mstatus through a handshaked
// CSR port, then redirects fetch. Define TRAP_VECTORED_EN for vectored mtvec.
module trap_ctrl
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic [63:0] exc_pc_i,
  input  logic [63:0] exc_tval_i,
  input  logic        mret_valid_i,
  output logic        req_ready_o,
  input  logic        irq_mei_i,
  input  logic        irq_msi_i,
  input  logic        irq_mti_i,
  input  logic [63:0] mstatus_i,
  input  logic [63:0] mie_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] mepc_i,
  output logic        csr_wr_valid_o,
  output logic [11:0] csr_wr_addr_o,
  output logic [63:0] csr_wr_data_o,
  input  logic        csr_wr_ready_i,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  logic [63:0] cause_q, cause_d, pc_q, pc_d, tval_q, tval_d;
  logic        is_irq_q, is_irq_d;
  logic        csr_wr_valid_q, csr_wr_valid_d;
  logic [11:0] csr_wr_addr_q, csr_wr_addr_d;
  logic [63:0] csr_wr_data_q, csr_wr_data_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic        busy_q, busy_d;

  logic [63:0] mip, tvec_base, trap_pc;
  logic        irq_pending, wr_done;
  logic [4:0]  irq_code;

  always_comb begin
    mip           = '0;
    mip[CODE_MEI] = irq_mei_i;
    mip[CODE_MSI] = irq_msi_i;
    mip[CODE_MTI] = irq_mti_i;
  end

  trap_irq_prio u_irq_prio (
    .mip_i     (mip),
    .mie_i     (mie_i),
    .gie_i     (mstatus_i[MSTATUS_MIE]),
    .pending_o (irq_pending),
    .code_o    (irq_code)
  );

  assign tvec_base = mtvec_i & ~64'h3;
`ifdef TRAP_VECTORED_EN
  assign trap_pc = (mtvec_i[1:0] == MTVEC_MODE_VEC && is_irq_q)
                 ? tvec_base + {57'd0, cause_q[4:0], 2'b00} : tvec_base;
`else
  logic unused_irq_flag;
  assign trap_pc         = tvec_base;
  assign unused_irq_flag = is_irq_q;
`endif

  assign wr_done = csr_wr_valid_q & csr_wr_ready_i;

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    pc_d             = pc_q;
    tval_d           = tval_q;
    is_irq_d         = is_irq_q;
    csr_wr_valid_d   = csr_wr_valid_q;
    csr_wr_addr_d    = csr_wr_addr_q;
    csr_wr_data_d    = csr_wr_data_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      IDLE: begin
        if (exc_valid_i) begin
          cause_d  = {59'd0, exc_code_i};
          pc_d     = exc_pc_i;
          tval_d   = exc_tval_i;
          is_irq_d = 1'b0;
          state_d  = WR_EPC;
        end else if (irq_pending) begin
          cause_d  = {1'b1, 58'd0, irq_code};
          pc_d     = exc_pc_i;
          tval_d   = '0;
          is_irq_d = 1'b1;
          state_d  = WR_EPC;
        end else if (mret_valid_i) begin
          state_d = MRET_STATUS;
        end
      end
      WR_EPC:      if (wr_done) state_d = WR_CAUSE;
      WR_CAUSE:    if (wr_done) state_d = WR_TVAL;
      WR_TVAL:     if (wr_done) state_d = WR_STATUS;
      WR_STATUS:   if (wr_done) state_d = REDIRECT;
      MRET_STATUS: if (wr_done) state_d = REDIRECT;
      default:     state_d = IDLE;
    endcase

    // Outputs are loaded on state entry and held while waiting for ready.
    if (state_d != state_q) begin
      csr_wr_valid_d = 1'b1;
      case (state_d)
        WR_EPC: begin
          csr_wr_addr_d = CSR_MEPC;
          csr_wr_data_d = pc_d & ~64'h3;
        end
        WR_CAUSE: begin
          csr_wr_addr_d = CSR_MCAUSE;
          csr_wr_data_d = cause_q;
        end
        WR_TVAL: begin
          csr_wr_addr_d = CSR_MTVAL;
          csr_wr_data_d = tval_q;
        end
        WR_STATUS: begin
          csr_wr_addr_d = CSR_MSTATUS;
          csr_wr_data_d = trap_mstatus(mstatus_i);
        end
        MRET_STATUS: begin
          csr_wr_addr_d = CSR_MSTATUS;
          csr_wr_data_d = mret_mstatus(mstatus_i);
        end
        REDIRECT: begin
          csr_wr_valid_d   = 1'b0;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = (state_q == MRET_STATUS) ? mepc_i : trap_pc;
        end
        default: csr_wr_valid_d = 1'b0;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= IDLE;
      cause_q          <= '0;
      pc_q             <= '0;
      tval_q           <= '0;
      is_irq_q         <= 1'b0;
      csr_wr_valid_q   <= 1'b0;
      csr_wr_addr_q    <= '0;
      csr_wr_data_q    <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cause_q          <= cause_d;
      pc_q             <= pc_d;
      tval_q           <= tval_d;
      is_irq_q         <= is_irq_d;
      csr_wr_valid_q   <= csr_wr_valid_d;
      csr_wr_addr_q    <= csr_wr_addr_d;
      csr_wr_data_q    <= csr_wr_data_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  assign csr_wr_valid_o   = csr_wr_valid_q;
  assign csr_wr_addr_o    = csr_wr_addr_q;
  assign csr_wr_data_o    = csr_wr_data_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign busy_o           = busy_q;
  assign req_ready_o      = ~busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vector table, randomized events against a
// transaction-level model, and reset-abort / stall sequences.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exc_valid_i, mret_valid_i, irq_mei_i, irq_msi_i, irq_mti_i;
  logic [4:0]  exc_code_i;
  logic [63:0] exc_pc_i, exc_tval_i, mstatus_i, mie_i, mtvec_i, mepc_i;
  logic        req_ready_o, csr_wr_valid_o, csr_wr_ready_i, redirect_valid_o, busy_o;
  logic [11:0] csr_wr_addr_o;
  logic [63:0] csr_wr_data_o, redirect_pc_o;

  int n_chk  = 0;
  int n_pass = 0;

  trap_ctrl dut (
    .clk              (clk),
    .resetn           (resetn),
    .exc_valid_i      (exc_valid_i),
    .exc_code_i       (exc_code_i),
    .exc_pc_i         (exc_pc_i),
    .exc_tval_i       (exc_tval_i),
    .mret_valid_i     (mret_valid_i),
    .req_ready_o      (req_ready_o),
    .irq_mei_i        (irq_mei_i),
    .irq_msi_i        (irq_msi_i),
    .irq_mti_i        (irq_mti_i),
    .mstatus_i        (mstatus_i),
    .mie_i            (mie_i),
    .mtvec_i          (mtvec_i),
    .mepc_i           (mepc_i),
    .csr_wr_valid_o   (csr_wr_valid_o),
    .csr_wr_addr_o    (csr_wr_addr_o),
    .csr_wr_data_o    (csr_wr_data_o),
    .csr_wr_ready_i   (csr_wr_ready_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        exc;
    logic [4:0]  code;
    logic [63:0] pc, tval;
    logic        mret, mei, msi, mti;
    logic [63:0] mstatus, mie, mtvec, mepc;
  } stim_t;

  typedef struct {
    int          kind;   // 0 none, 1 trap, 2 mret
    logic [63:0] cause, epc, tval, status, redir;
  } exp_t;

  typedef struct {
    stim_t       s;
    exp_t        e;
    logic [11:0] stall_addr;
    int          stall_n;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: derives the whole expected transaction from the rules.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    int   codes[3];
    logic lines[3];
    logic [63:0] base;
    codes = '{11, 3, 7};
    lines = '{s.mei, s.msi, s.mti};
    e = '{0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    if (s.exc) begin
      e.kind = 1; e.cause = 64'(s.code); e.tval = s.tval;
    end else if (s.mstatus[3]) begin
      for (int k = 0; k < 3; k++)
        if (e.kind == 0 && lines[k] && s.mie[codes[k]]) begin
          e.kind = 1; e.cause = (64'd1 << 63) + 64'(codes[k]); e.tval = 64'd0;
        end
    end
    if (e.kind == 0 && s.mret) e.kind = 2;
    e.epc = s.pc & ~64'h3;
    if (e.kind == 1) begin
      e.status = (s.mstatus & ~64'h1888) | 64'h1800 | (s.mstatus[3] ? 64'h80 : 64'h0);
      base = s.mtvec & ~64'h3;
      e.redir = base;
`ifdef TRAP_VECTORED_EN
      if (s.mtvec[1:0] == 2'b01 && e.cause[63]) e.redir = base + 4 * (e.cause & 64'h1f);
`endif
    end else if (e.kind == 2) begin
      e.status = (s.mstatus & ~64'h1888) | 64'h1880 | (s.mstatus[7] ? 64'h8 : 64'h0);
      e.redir  = s.mepc;
    end
    return e;
  endfunction

  task automatic run_txn(input string tag, input vec_t v);
    logic [11:0] wa[$], ea[$];
    logic [63:0] wd[$], ed[$];
    logic [11:0] held_a;
    logic [63:0] held_d, rpc;
    bit          held_set, seen, in_path;
    int          stall_left, rcyc, exp_lat;
    @(negedge clk);
    chk({tag, ".idle_ready"}, 64'(req_ready_o), 64'd1);
    exc_valid_i = v.s.exc; exc_code_i = v.s.code; exc_pc_i = v.s.pc; exc_tval_i = v.s.tval;
    mret_valid_i = v.s.mret; irq_mei_i = v.s.mei; irq_msi_i = v.s.msi; irq_mti_i = v.s.mti;
    mstatus_i = v.s.mstatus; mie_i = v.s.mie; mtvec_i = v.s.mtvec; mepc_i = v.s.mepc;
    csr_wr_ready_i = 1'b1;
    @(negedge clk);
    exc_valid_i = 1'b0; mret_valid_i = 1'b0; irq_mei_i = 1'b0; irq_msi_i = 1'b0; irq_mti_i = 1'b0;
    if (v.e.kind == 0) begin
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
        seen |= busy_o | csr_wr_valid_o | redirect_valid_o;
        @(negedge clk);
      end
      chk({tag, ".no_event"}, 64'(seen), 64'd0);
      return;
    end
    chk({tag, ".busy"}, 64'({busy_o, req_ready_o}), 64'b10);
    held_set = 1'b0; stall_left = v.stall_n; rcyc = -1; rpc = '0;
    for (int cyc = 1; cyc <= 20 && rcyc < 0; cyc++) begin
      if (redirect_valid_o) begin
        rcyc = cyc; rpc = redirect_pc_o;
        chk({tag, ".redir_no_wr"}, 64'(csr_wr_valid_o), 64'd0);
      end else if (csr_wr_valid_o) begin
        if (v.stall_n > 0 && csr_wr_addr_o == v.stall_addr) begin
          if (!held_set) begin
            held_set = 1'b1; held_a = csr_wr_addr_o; held_d = csr_wr_data_o;
          end else begin
            chk({tag, ".hold_addr"}, 64'(csr_wr_addr_o), 64'(held_a));
            chk({tag, ".hold_data"}, csr_wr_data_o, held_d);
          end
        end
        if (stall_left > 0 && csr_wr_addr_o == v.stall_addr) begin
          stall_left--; csr_wr_ready_i = 1'b0;
        end else begin
          csr_wr_ready_i = 1'b1; wa.push_back(csr_wr_addr_o); wd.push_back(csr_wr_data_o);
        end
      end else begin
        csr_wr_ready_i = 1'b1;
      end
      if (rcyc < 0) @(negedge clk);
    end
    csr_wr_ready_i = 1'b1;
    if (v.e.kind == 1) begin
      ea = '{12'h341, 12'h342, 12'h343, 12'h300};
      ed = '{v.e.epc, v.e.cause, v.e.tval, v.e.status};
      exp_lat = 5;
    end else begin
      ea = '{12'h300};
      ed = '{v.e.status};
      exp_lat = 2;
    end
    in_path = 1'b0;
    foreach (ea[i]) if (ea[i] == v.stall_addr) in_path = 1'b1;
    if (in_path) exp_lat += v.stall_n;
    chk({tag, ".redirect_seen"}, 64'(rcyc >= 0), 64'd1);
    chk({tag, ".n_writes"}, 64'(wa.size()), 64'(ea.size()));
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      chk($sformatf("%s.wr%0d_addr", tag, i), 64'(wa[i]), 64'(ea[i]));
      chk($sformatf("%s.wr%0d_data", tag, i), wd[i], ed[i]);
    end
    chk({tag, ".redirect_pc"}, rpc, v.e.redir);
    chk({tag, ".latency"}, 64'(rcyc), 64'(exp_lat));
    @(negedge clk);
    chk({tag, ".post_idle"}, 64'({redirect_valid_o, busy_o, req_ready_o}), 64'b001);
  endtask

  vec_t        vecs[10];
  vec_t        rv;
  logic [11:0] stall_sel[4];
  logic [63:0] vec_redir1, vec_redir4;
  bit          seen;

  initial begin
    vec_redir1 = 64'h1000;
    vec_redir4 = 64'h3000_0000;
`ifdef TRAP_VECTORED_EN
    vec_redir1 = 64'h101C;
    vec_redir4 = 64'h3000_002C;
`endif
    //          exc code  pc                     tval                   mret mei msi mti mstatus                mie      mtvec                  mepc
    vecs[0] = '{'{1'b1, 5'd2,  64'h8000_0104, 64'h13, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8, 64'h0, 64'h8000_0000, 64'h0},
                '{1, 64'd2, 64'h8000_0104, 64'h13, 64'h1880, 64'h8000_0000}, 12'h000, 0};
    vecs[1] = '{'{1'b0, 5'd0,  64'h2000_0003, 64'h55, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8, 64'h80, 64'h1001, 64'h0},
                '{1, 64'h8000_0000_0000_0007, 64'h2000_0000, 64'h0, 64'h1880, vec_redir1}, 12'h000, 0};
    vecs[2] = '{'{1'b0, 5'd0,  64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1880, 64'h0, 64'h0, 64'h4000},
                '{2, 64'h0, 64'h0, 64'h0, 64'h1888, 64'h4000}, 12'h000, 0};
    vecs[3] = '{'{1'b1, 5'd5,  64'h100, 64'hdead, 1'b1, 1'b1, 1'b0, 1'b0, 64'h8, 64'h800, 64'h200, 64'h0},
                '{1, 64'd5, 64'h100, 64'hdead, 64'h1880, 64'h200}, 12'h342, 3};
    vecs[4] = '{'{1'b0, 5'd0,  64'h44, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8, 64'h888, 64'h3000_0001, 64'h0},
                '{1, 64'h8000_0000_0000_000B, 64'h44, 64'h0, 64'h1880, vec_redir4}, 12'h000, 0};
    vecs[5] = '{'{1'b0, 5'd0,  64'h48, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8, 64'h888, 64'h1000, 64'h0},
                '{1, 64'h8000_0000_0000_0003, 64'h48, 64'h0, 64'h1880, 64'h1000}, 12'h300, 2};
    vecs[6] = '{'{1'b0, 5'd0,  64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h80, 64'h888, 64'h0, 64'h5554},
                '{2, 64'h0, 64'h0, 64'h0, 64'h1888, 64'h5554}, 12'h300, 1};
    vecs[7] = '{'{1'b0, 5'd0,  64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8, 64'h8, 64'h0, 64'h0},
                '{0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, 12'h000, 0};
    vecs[8] = '{'{1'b1, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0,
                  64'hA000_0000_0000_0022, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
                '{1, 64'h1F, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA000_0000_0000_1822,
                  64'hFFFF_FFFF_FFFF_FFFC}, 12'h341, 1};
    vecs[9] = '{'{1'b0, 5'd0,  64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8, 64'h0, 64'h0, 64'h8000_0002},
                '{2, 64'h0, 64'h0, 64'h0, 64'h1880, 64'h8000_0002}, 12'h000, 0};
    stall_sel = '{12'h341, 12'h342, 12'h343, 12'h300};

    resetn = 1'b0; exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0; exc_tval_i = '0;
    mret_valid_i = 1'b0; irq_mei_i = 1'b0; irq_msi_i = 1'b0; irq_mti_i = 1'b0;
    mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0; csr_wr_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset.flags", 64'({req_ready_o, busy_o, csr_wr_valid_o, redirect_valid_o}), 64'b1000);
    chk("reset.addr", 64'(csr_wr_addr_o), 64'd0);
    chk("reset.data", csr_wr_data_o, 64'd0);
    chk("reset.redirect_pc", redirect_pc_o, 64'd0);

    for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 40; i++) begin
      rv.s.exc  = ($urandom_range(0, 3) == 0);
      rv.s.code = 5'($urandom);
      rv.s.pc   = {$urandom, $urandom};
      rv.s.tval = {$urandom, $urandom};
      rv.s.mret = 1'($urandom_range(0, 1));
      rv.s.mei  = ($urandom_range(0, 2) == 0);
      rv.s.msi  = ($urandom_range(0, 2) == 0);
      rv.s.mti  = ($urandom_range(0, 2) == 0);
      rv.s.mstatus = {$urandom, $urandom};
      rv.s.mie     = {$urandom, $urandom};
      rv.s.mtvec   = {$urandom, $urandom};
      rv.s.mepc    = {$urandom, $urandom};
      rv.e          = model(rv.s);
      rv.stall_addr = stall_sel[$urandom_range(0, 3)];
      rv.stall_n    = $urandom_range(0, 3);
      run_txn($sformatf("rnd%0d", i), rv);
    end

    // Reset while mtval write is pending: sequence must die silently.
    @(negedge clk);
    exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 64'h900; exc_tval_i = 64'h77;
    mstatus_i = 64'h8; mtvec_i = 64'h100; csr_wr_ready_i = 1'b1;
    @(negedge clk);
    exc_valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (csr_wr_valid_o && csr_wr_addr_o == 12'h343) begin
        seen = 1'b1; csr_wr_ready_i = 1'b0;
      end else @(negedge clk);
    end
    chk("abort.reached_tval", 64'(seen), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1; csr_wr_ready_i = 1'b1;
    chk("abort.idle", 64'({req_ready_o, busy_o, csr_wr_valid_o, redirect_valid_o}), 64'b1000);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= csr_wr_valid_o | redirect_valid_o | busy_o;
    end
    chk("abort.quiet", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: exc_valid_i  input  1  synchronous exception request from pipeline; exc_code_i  input  5  cause code; exc_pc_i  input  64  faulting PC; exc_tval_i  input  64  trap value.
REQ-004 SHALL have: mret_valid_i  input  1  MRET retiring.
REQ-005 SHALL have: req_ready_o  output  1  request accepted this cycle (high only in IDLE).
REQ-006 SHALL have: irq_mei_i, irq_msi_i, irq_mti_i  input  1 each  level interrupt lines.
REQ-007 SHALL have: mstatus_i, mie_i, mtvec_i, mepc_i  input  64 each  current CSR values.
REQ-008 SHALL have: csr_wr_valid_o  output  1; csr_wr_addr_o  output  12; csr_wr_data_o  output  64; csr_wr_ready_i  input  1  CSR write-port handshake.
REQ-009 SHALL have: redirect_valid_o  output  1  one-cycle pulse; redirect_pc_o  output  64  fetch target; busy_o  output  1  pipeline stall/flush while sequencing.

Function
REQ-010 SHALL use states IDLE, WR_EPC, WR_CAUSE, WR_TVAL, WR_STATUS, MRET_STATUS, REDIRECT.
REQ-011 IDLE SHALL accept exactly one event per cycle, priority: exception > pending interrupt > MRET; lower-priority events SHALL be ignored (requester holds).
REQ-012 Pending interrupt SHALL be mstatus_i[3] & |(mip & mie_i), mip = {bit11 MEI, bit3 MSI, bit7 MTI}; interrupt priority MEI > MSI > MTI.
REQ-013 On accept, cause, PC, tval and an is_irq flag SHALL be latched; interrupts latch tval = 0, PC = exc_pc_i, cause = {1'b1, 58'b0, code} with code 11/3/7.
REQ-014 Trap path SHALL be IDLE -> WR_EPC (0x341, {pc[63:2],2'b00}) -> WR_CAUSE (0x342) -> WR_TVAL (0x343) -> WR_STATUS (0x300) -> REDIRECT -> IDLE.
REQ-015 Trap mstatus data SHALL be mstatus_i with bit7 (MPIE) = bit3, bit3 (MIE) = 0, bits12:11 = 2'b11.
REQ-016 MRET path SHALL be IDLE -> MRET_STATUS (0x300, MIE = MPIE, MPIE = 1, MPP = 2'b11) -> REDIRECT, redirect_pc_o = mepc_i.
REQ-017 Each WR_* state SHALL hold csr_wr_valid_o and addr/data stable until csr_wr_ready_i high; advance on valid & ready; zero-wait ready gives one cycle per write.
REQ-018 Trap redirect_pc_o SHALL be {mtvec_i[63:2],2'b00} (direct mode).
REQ-019 redirect_valid_o SHALL be high for exactly one cycle in REDIRECT; minimum trap latency accept-to-redirect 5 cycles, MRET 2 cycles.
REQ-020 busy_o SHALL be high in every state except IDLE; req_ready_o = ~busy_o.
REQ-021 csr_wr_valid_o SHALL be 0 in IDLE and REDIRECT.

Reset
REQ-022 On resetn low at a clock edge: state IDLE, all latched registers 0, all outputs 0 except req_ready_o = 1.
REQ-023 Reset mid-sequence SHALL abort with no further CSR writes or redirect.

Configuration
REQ-024 Macro TRAP_VECTORED_EN defined: if mtvec_i[1:0] == 2'b01 and is_irq, redirect_pc_o = {mtvec_i[63:2],2'b00} + 4*code (64-bit wrap).
REQ-025 Macro absent: mtvec_i[1:0] ignored, always direct mode per REQ-018.

Structure
REQ-026 Package trap_pkg SHALL hold state enum, CSR addresses (0x300/0x341/0x342/0x343), interrupt cause codes, mstatus bit positions.
REQ-027 Interrupt priority encode SHALL be sub-module trap_irq_prio (inputs mip, mie, global enable; outputs pending, code).

Verification
REQ-028 exc_valid_i=1, code=2, pc=0x8000_0104, tval=0x13, mtvec=0x8000_0000, ready=1 -> writes 0x341=0x8000_0104, 0x342=2, 0x343=0x13, 0x300 MIE=0 MPIE=old MIE MPP=3; redirect 0x8000_0000 on cycle 5.
REQ-029 mstatus MIE=1, mie bit7=1, irq_mti_i=1 -> mcause=0x8000_0000_0000_0007, mtval=0; with TRAP_VECTORED_EN and mtvec=0x1001 -> redirect 0x101C.
REQ-030 MRET, mstatus=0x1880, mepc=0x4000 -> write 0x300 data 0x1888, redirect 0x4000 two cycles after accept.
REQ-031 exc_valid_i, irq_mei_i, mret_valid_i same cycle -> exception taken; csr_wr_ready_i low 3 cycles in WR_CAUSE -> addr/data held, latency +3.
REQ-032 resetn low during WR_TVAL -> next cycle IDLE, no 0x300 write, no redirect pulse.
